// File: rtl/lin_interp_upsampler.sv
// Audio-rate to modulator-rate upsampler: 2-entry input FIFO feeding a linear interpolator
// that produces one sample per enabled clock, ramping from x_prev to x_cur over OSR cycles.
module lin_interp_upsampler #(
  parameter int unsigned IN_W     = 19,
  parameter int unsigned OSR      = 64,
  parameter int unsigned LOG2_OSR = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IN_W-1:0]     out,
  output logic                out_valid,
  output logic                underflow,
  output logic [LOG2_OSR-1:0] phase
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  localparam logic [LOG2_OSR-1:0] LastPhase = LOG2_OSR'(OSR - 1);

  logic [IN_W-1:0]     mem_q [2];
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [1:0]          state_q, state_d;
  logic [IN_W-1:0]     x_prev_q, x_prev_d, x_cur_q, x_cur_d;
  logic [LOG2_OSR-1:0] phase_q, phase_d;
  logic [IN_W-1:0]     out_q, out_d;
  logic                underflow_q, underflow_d;

  logic                push, pop, fifo_nonempty, wrap;
  logic [IN_W-1:0]     head, interp;
  logic signed [IN_W:0]          diff, step;
  logic signed [IN_W+LOG2_OSR:0] prod;

  assign fifo_nonempty = (cnt_q != 2'd0);
  assign wrap          = (phase_q == LastPhase);
  assign head          = mem_q[rd_ptr_q];
  assign push          = in_valid && ready_q;
  assign pop           = en && fifo_nonempty &&
                         ((state_q == StRun) || (state_q == StHold) ? wrap : 1'b1);

  // Interpolation: the arithmetic shift of the full product floors toward -inf.
  assign diff   = {x_cur_q[IN_W-1], x_cur_q} - {x_prev_q[IN_W-1], x_prev_q};
  assign prod   = $signed({{LOG2_OSR{diff[IN_W]}}, diff}) *
                  $signed({{(IN_W+1){1'b0}}, phase_q});
  assign step   = (IN_W+1)'(prod >>> LOG2_OSR);
  assign interp = IN_W'({x_prev_q[IN_W-1], x_prev_q} + step);

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    x_prev_d    = x_prev_q;
    x_cur_d     = x_cur_q;
    phase_d     = phase_q;
    out_d       = out_q;
    underflow_d = underflow_q;
    if (en) begin
      case (state_q)
        StRun, StHold: begin
          out_d   = interp;
          phase_d = phase_q + LOG2_OSR'(1);
          if (wrap) begin
            x_prev_d = x_cur_q;
            if (fifo_nonempty) begin
              x_cur_d = head;
              state_d = StRun;
            end else begin
              underflow_d = 1'b1;
              state_d     = StHold;
            end
          end
        end
        default: begin
          out_d = '0;
          if (fifo_nonempty) begin
            x_cur_d  = head;
            x_prev_d = '0;
            phase_d  = '0;
            state_d  = StRun;
          end else begin
            state_d = StEmpty;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      ready_q     <= 1'b1;
      state_q     <= StEmpty;
      x_prev_q    <= '0;
      x_cur_q     <= '0;
      phase_q     <= '0;
      out_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      state_q     <= state_d;
      x_prev_q    <= x_prev_d;
      x_cur_q     <= x_cur_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready  = ready_q;
  assign out       = out_q;
  assign out_valid = (state_q != StEmpty);
  assign underflow = underflow_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_lin_interp_upsampler.sv
// Directed bench for lin_interp_upsampler: ramp, floor, backpressure, en gating,
// full-scale swing and mid-run reset, with hand-derived expected values.
module tb_lin_interp_upsampler;

  localparam int unsigned IN_W     = 19;
  localparam int unsigned OSR      = 64;
  localparam int unsigned LOG2_OSR = 6;

  logic                clk = 1'b0;
  logic                rst, en, in_valid;
  logic [IN_W-1:0]     in_data;
  logic                in_ready, out_valid, underflow;
  logic [IN_W-1:0]     out;
  logic [LOG2_OSR-1:0] phase;

  int total = 0;
  int bad   = 0;

  lin_interp_upsampler #(
    .IN_W    (IN_W),
    .OSR     (OSR),
    .LOG2_OSR(LOG2_OSR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .underflow(underflow),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int starts[$];
    int accepted;
    int prev;
    int exp;
    logic acc;

    // Reset state
    do_reset();
    chk("rst_out", $signed(out), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_underflow", underflow, 0);
    chk("rst_phase", phase, 0);

    // Ramp-up: 64 then 128
    in_data = 19'd64; in_valid = 1'b1;
    tick();
    chk("ramp_empty_out", $signed(out), 0);
    chk("ramp_empty_valid", out_valid, 0);
    in_data = 19'd128;
    tick();
    in_valid = 1'b0;
    chk("ramp_loaded_valid", out_valid, 1);
    chk("ramp_loaded_phase", phase, 0);
    for (int p = 0; p < 64; p++) begin
      tick();
      chk("ramp_p1_out", $signed(out), p);
      chk("ramp_p1_phase", phase, (p + 1) % 64);
      chk("ramp_p1_uflow", underflow, 0);
    end
    for (int p = 0; p < 64; p++) begin
      tick();
      chk("ramp_p2_out", $signed(out), 64 + p);
      chk("ramp_p2_phase", phase, (p + 1) % 64);
      chk("ramp_p2_uflow", underflow, (p == 63) ? 1 : 0);
    end
    tick();
    chk("ramp_hold_out", $signed(out), 128);
    chk("ramp_hold_valid", out_valid, 1);

    // Negative floor: -1 into EMPTY
    do_reset();
    in_data = 19'h7FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int p = 0; p < 64; p++) begin
      tick();
      chk("neg_out", $signed(out), (p == 0) ? 0 : -1);
    end
    chk("neg_uflow", underflow, 1);
    for (int p = 0; p < 64; p++) begin
      tick();
      chk("neg_hold_out", $signed(out), -1);
    end
    chk("neg_uflow_sticky", underflow, 1);

    // Backpressure: 100,200,300,400 offered continuously
    do_reset();
    accepted = 0;
    in_data = 19'd100; in_valid = 1'b1;
    for (int c = 0; c < 400 && starts.size() < 5; c++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        accepted++;
        in_data  = IN_W'(100 * (accepted + 1));
        in_valid = (accepted < 4);
      end
      if (c == 2) chk("bp_ready_drop", in_ready, 0);
      if (phase == 1) starts.push_back(int'($signed(out)));
    end
    chk("bp_accepted", accepted, 4);
    chk("bp_starts", starts.size(), 5);
    for (int i = 0; i < starts.size() && i < 5; i++) chk("bp_seq", starts[i], 100 * i);

    // en gating: x_prev=0, x_cur=640
    do_reset();
    in_data = 19'd640; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    repeat (11) tick();
    chk("en_pre_out", $signed(out), 100);
    chk("en_pre_phase", phase, 11);
    en = 1'b0;
    in_data = 19'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b0;
      chk("en_hold_out", $signed(out), 100);
      chk("en_hold_phase", phase, 11);
    end
    en = 1'b1;
    tick();
    chk("en_resume_out1", $signed(out), 110);
    tick();
    chk("en_resume_out2", $signed(out), 120);

    // Full-scale swing -2^18 -> 2^18-1
    do_reset();
    in_data = 19'h40000; in_valid = 1'b1;
    tick();
    in_data = 19'h3FFFF;
    tick();
    in_valid = 1'b0;
    repeat (64) tick();
    chk("fs_p1_last", $signed(out), -258048);
    prev = -262145;
    for (int p = 0; p < 64; p++) begin
      tick();
      exp = -262144 + ((524287 * p) / 64);
      chk("fs_out", $signed(out), exp);
      chk("fs_monotonic", ($signed(out) >= prev) ? 1 : 0, 1);
      prev = int'($signed(out));
    end
    tick();
    chk("fs_next_period", $signed(out), 262143);

    // Reset mid-run with two samples buffered
    do_reset();
    in_data = 19'd1000; in_valid = 1'b1;
    tick();
    in_data = 19'd2000;
    tick();
    in_data = 19'd3000;
    tick();
    in_valid = 1'b0;
    chk("mr_full_ready", in_ready, 0);
    for (int c = 0; c < 100 && phase != 30; c++) tick();
    chk("mr_phase30", phase, 30);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    chk("mr_out", $signed(out), 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_underflow", underflow, 0);
    chk("mr_phase", phase, 0);
    for (int c = 0; c < 70; c++) begin
      tick();
      chk("mr_stays_empty", out_valid, 0);
      chk("mr_stays_zero", $signed(out), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
